// File: rtl/can_pkg.sv
// can_pkg: shared CAN types and constants for the bit stuffer and destuffer
package can_pkg;
  typedef enum logic [1:0] {IDLE, DATA, STUFF} stuff_state_t;
  localparam logic CAN_RECESSIVE = 1'b1;
  localparam int CAN_STUFF_LIMIT = 5;
  localparam int CAN_EOF_TICKS = 11;
endpackage

// File: rtl/can_bit_stuffer_if.sv
// can_bit_stuffer_if: serializer-to-stuffer bit stream and TX status (master = serializer, slave = stuffer)
interface can_bit_stuffer_if;
  logic tx_tick;
  logic frame_start;
  logic stuff_en;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;
  logic tx;
  logic stuff_inserted;
  logic underrun;
  modport master (
    output tx_tick, frame_start, stuff_en, bit_in, bit_valid,
    input  bit_ready, tx, stuff_inserted, underrun
  );
  modport slave (
    input  tx_tick, frame_start, stuff_en, bit_in, bit_valid,
    output bit_ready, tx, stuff_inserted, underrun
  );
endinterface

// File: rtl/can_bit_stuffer.sv
// can_bit_stuffer: transmit-side CAN bit stuffer; ports clk, reset (async active-low), bus (slave modport)
module can_bit_stuffer
  import can_pkg::*;
#(
  parameter int STUFF_LIMIT = CAN_STUFF_LIMIT
) (
  input logic clk,
  input logic reset,
  can_bit_stuffer_if.slave bus
);
  localparam int CW = $clog2(STUFF_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STUFF_LIMIT);
  stuff_state_t state, state_nx;
  logic last_bit, last_bit_nx;
  logic [CW-1:0] run_cnt, run_cnt_nx, run_inc;
  logic [3:0] idle_cnt, idle_cnt_nx;
  logic tx_nx, stuff_nx, underrun_nx;
  logic tick, take, starve, emit_stuff, eof;
  // frame_start outranks any tick, so a coincident tick is ignored
  assign tick = bus.tx_tick && !bus.frame_start;
  assign take = state == DATA && tick && bus.bit_valid;
  assign starve = state == DATA && tick && !bus.bit_valid;
  assign emit_stuff = state == STUFF && tick;
  // frame end: a run of empty pass-through ticks spanning EOF plus intermission
  assign eof = starve && !bus.stuff_en && idle_cnt == 4'(CAN_EOF_TICKS - 1);
  assign run_inc = bus.bit_in != last_bit ? CW'(1) :
                   run_cnt == LIMIT ? run_cnt : run_cnt + CW'(1);
  assign bus.bit_ready = state == DATA && tick;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      last_bit <= CAN_RECESSIVE;
      run_cnt <= '0;
      idle_cnt <= '0;
      bus.tx <= CAN_RECESSIVE;
      bus.stuff_inserted <= 1'b0;
      bus.underrun <= 1'b0;
    end else begin
      state <= state_nx;
      last_bit <= last_bit_nx;
      run_cnt <= run_cnt_nx;
      idle_cnt <= idle_cnt_nx;
      bus.tx <= tx_nx;
      bus.stuff_inserted <= stuff_nx;
      bus.underrun <= underrun_nx;
    end
  // STUFF, once entered, is honoured even if stuff_en has already dropped
  always_comb
    state_nx = bus.frame_start ? DATA :
               take && bus.stuff_en && run_inc == LIMIT ? STUFF :
               emit_stuff ? DATA :
               eof ? IDLE : state;
  always_comb begin
    tx_nx = take ? bus.bit_in : emit_stuff ? ~last_bit : starve ? CAN_RECESSIVE : bus.tx;
    stuff_nx = emit_stuff;
    underrun_nx = starve;
    last_bit_nx = bus.frame_start ? CAN_RECESSIVE :
                  take && bus.stuff_en ? bus.bit_in :
                  emit_stuff ? ~last_bit : last_bit;
    // the stuff bit itself opens the next run with length 1
    run_cnt_nx = bus.frame_start ? '0 :
                 take ? (bus.stuff_en ? run_inc : '0) :
                 emit_stuff ? CW'(1) : run_cnt;
    idle_cnt_nx = starve && !bus.stuff_en ? idle_cnt + 4'd1 :
                  bus.tx_tick || bus.frame_start ? 4'd0 : idle_cnt;
  end
endmodule

// File: tb/tb_can_bit_stuffer.sv
// tb_can_bit_stuffer: directed self-checking bench for can_bit_stuffer
module tb_can_bit_stuffer;
  import can_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  can_bit_stuffer_if bus();
  can_bit_stuffer dut (.clk(clk), .reset(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic start();
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask
  task automatic do_tick(input string tag, input logic b, v, se, erdy, etx, est, eur);
    @(negedge clk);
    check({tag, " pulse_clear"}, {6'd0, bus.stuff_inserted, bus.underrun}, 8'd0);
    bus.bit_in = b;
    bus.bit_valid = v;
    bus.stuff_en = se;
    bus.tx_tick = 1'b1;
    #1 check({tag, " bit_ready"}, 8'(bus.bit_ready), 8'(erdy));
    @(negedge clk);
    bus.tx_tick = 1'b0;
    bus.bit_valid = 1'b0;
    check({tag, " tx"}, 8'(bus.tx), 8'(etx));
    check({tag, " stuff_inserted"}, 8'(bus.stuff_inserted), 8'(est));
    check({tag, " underrun"}, 8'(bus.underrun), 8'(eur));
  endtask
  initial begin
    bus.tx_tick = 0;
    bus.frame_start = 0;
    bus.stuff_en = 0;
    bus.bit_in = 0;
    bus.bit_valid = 0;
    #12;
    check("reset tx", 8'(bus.tx), 8'd1);
    check("reset bit_ready", 8'(bus.bit_ready), 8'd0);
    check("reset pulses", {6'd0, bus.stuff_inserted, bus.underrun}, 8'd0);
    check("reset state", 8'(dut.state), 8'(IDLE));
    check("reset run_cnt", 8'(dut.run_cnt), 8'd0);
    @(negedge clk) rst_n = 1'b1;
    do_tick("idle", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    start();
    for (int i = 0; i < 5; i++) do_tick("zeros", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_tick("zeros stuff", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    do_tick("zeros after", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("zeros run_cnt", 8'(dut.run_cnt), 8'd2);
    start();
    for (int i = 0; i < 5; i++) do_tick("ones", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    do_tick("ones stuff", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) do_tick("next run", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_tick("next run stuff", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    start();
    for (int i = 0; i < 6; i++) do_tick("pass", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("pass run_cnt", 8'(dut.run_cnt), 8'd0);
    check("pass state", 8'(dut.state), 8'(DATA));
    start();
    for (int i = 0; i < 5; i++) do_tick("eor", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_tick("eor stuff", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    do_tick("eor next", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    start();
    for (int i = 0; i < 3; i++) do_tick("ur pre", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_tick("ur gap", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("ur run_cnt", 8'(dut.run_cnt), 8'd3);
    for (int i = 0; i < 2; i++) do_tick("ur post", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_tick("ur stuff", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    start();
    for (int i = 0; i < 5; i++) do_tick("rst pre", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst in stuff", 8'(dut.state), 8'(STUFF));
    @(negedge clk) rst_n = 1'b0;
    #1 check("rst async tx", 8'(bus.tx), 8'd1);
    check("rst state", 8'(dut.state), 8'(IDLE));
    @(negedge clk) rst_n = 1'b1;
    do_tick("rst after", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    start();
    do_tick("end bit", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) do_tick("end gap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("end still data", 8'(dut.state), 8'(DATA));
    do_tick("end last", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("end idle", 8'(dut.state), 8'(IDLE));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/can_bit_stuffer.md
# can_bit_stuffer

Transmit-side bit-stuffing stage of the CAN controller. It sits between the frame serializer and the TX pin driver. On each transmit-point tick it drives one bit onto `tx`. Inside the stuffing region it automatically inserts a complementary stuff bit after every `STUFF_LIMIT` consecutive equal bits. It is the inverse of the receive-side destuffing block: both use the same run-length rule, so a stuffed stream round-trips exactly.

## Interface

- `STUFF_LIMIT`, default 5: run length of equal bits that triggers one stuff bit.
- `clk` input 1: single system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `tx_tick` input 1: one-`clk` pulse at each bit-time transmit point.
- `frame_start` input 1: one-`clk` pulse marking the start of a frame, before the SOF bit tick; clears the run state.
- `stuff_en` input 1: 1 means stuffing is active (SOF through the last CRC bit); 0 means pass-through (CRC delimiter onward).
- `bit_in` input 1: next frame bit from the serializer.
- `bit_valid` input 1: `bit_in` is valid.
- `bit_ready` output 1: combinational; high when a `bit_in` will be consumed this cycle.
- `tx` output 1: registered transmit bit; 1 is recessive.
- `stuff_inserted` output 1: one-`clk` pulse when a stuff bit is driven.
- `underrun` output 1: one-`clk` pulse when a tick finds no valid data while in `DATA`.

## Operation

- State machine: `IDLE`, `DATA`, `STUFF`.
- Internal state: `last_bit` (1 bit), `run_cnt` (`$clog2(STUFF_LIMIT+1)` bits, saturating, never wraps).
- `IDLE`:
  - `tx` = 1; `bit_ready` = 0.
  - `frame_start` moves to `DATA`, with `run_cnt` = 0 and `last_bit` = 1.
- `DATA`:
  - `bit_ready` = `tx_tick`.
  - On `tx_tick && bit_valid`: `tx` <= `bit_in` and the bit is consumed.
  - If `stuff_en` = 1:
    - If `bit_in == last_bit`, `run_cnt` <= `run_cnt`+1; otherwise `run_cnt` <= 1.
    - `last_bit` <= `bit_in`.
    - If the new `run_cnt` equals `STUFF_LIMIT`, go to `STUFF`.
  - If `stuff_en` = 0: `run_cnt` <= 0 and no stuffing.
- `STUFF`:
  - `bit_ready` = 0.
  - On `tx_tick`: `tx` <= `~last_bit`, pulse `stuff_inserted`, `last_bit` <= `~last_bit`, `run_cnt` <= 1 (the stuff bit starts the next run), then return to `DATA`.
- Underrun: `tx_tick` in `DATA` with `bit_valid` = 0 means:
  - `tx` <= 1 and `underrun` pulses.
  - `run_cnt` and `last_bit` are unchanged.
  - The state stays `DATA`.
- Stuff at the end of the region: `STUFF` entered on the last stuffed bit is honoured even if `stuff_en` falls before the next tick. This covers a stuff bit after the final CRC bit.
- Simultaneous events:
  - `frame_start` has priority over `tx_tick` in any state; `DATA`/`STUFF` restart with cleared run state.
  - `stuff_en` is sampled on the same tick as the bit it qualifies.
- Frame end: the serializer returns the block to `IDLE` by asserting `frame_start` = 0 and `stuff_en` = 0 while holding `bit_valid` low for 11 ticks. Alternatively, reset does it.

## Timing

- Reset values: `tx` = 1, `bit_ready` = 0, `stuff_inserted` = 0, `underrun` = 0, state `IDLE`, `run_cnt` = 0, `last_bit` = 1.
- Reset mid-operation: `tx` returns to 1 immediately (asynchronously); any pending stuff bit is discarded.
- `tx` updates on the `clk` edge that samples `tx_tick`, i.e. 1 `clk` latency. It holds until the next tick.
- `stuff_inserted` and `underrun` are high for exactly the `clk` following the sampling tick, aligned with the `tx` update.
- Handshake: a transfer occurs only when `bit_valid && bit_ready` in the same cycle. At most one bit is consumed per tick. The serializer must hold `bit_in` stable while `bit_valid` is high and not consumed.
- Throughput: one bit per tick, minus one tick per stuff bit.

## Structure

- Shared package `can_pkg` contains:
  - `stuff_state_t` enum (`IDLE`, `DATA`, `STUFF`);
  - `CAN_RECESSIVE` = 1'b1;
  - `CAN_STUFF_LIMIT` = 5, used as the parameter default by both the stuffer and the destuffer.
- Single module; no sub-module. The run counter is small enough to stay inline.

## Test plan

- Stuff on zeros: `frame_start`, then `stuff_en` = 1 with bits 0,0,0,0,0,1 → `tx` sequence 0,0,0,0,0,1(stuff),1; `stuff_inserted` high once, on tick 6; `bit_ready` low on tick 6.
- Stuff bit counts in the next run: bits 1,1,1,1,1,0,0,0,0 → `tx` 1,1,1,1,1,0(stuff),0,0,0,0,1(stuff); two `stuff_inserted` pulses.
- Pass-through: `stuff_en` = 0 with six 1s → `tx` = six 1s, no stuff pulses, `run_cnt` = 0.
- End-of-region stuff: five 0s, with `stuff_en` dropping right after the 5th tick → 6th tick still drives 1 (stuff); the 7th tick consumes the next bit.
- Underrun: `bit_valid` = 0 on a tick in `DATA` → `tx` = 1, `underrun` pulses once, and the following valid bits continue the run count unchanged.
- Reset mid-stuff: assert `reset` low while in `STUFF` → `tx` = 1 at once, state `IDLE`, and no `stuff_inserted` after release.
